// File: rtl/fifo_bist_ctrl.sv
// Self-test sequencer for an ECC-protected FIFO: writes a 2**M word pattern burst,
// reads it back and scores data, single-bit-inject and double-bit flags.
module fifo_bist_ctrl #(
    parameter int N = 32,
    parameter int M = 3
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         start_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
    output logic         fifo_err_o,
    output logic [7:0]   err_cnt_o,
    output logic [N-1:0] fifo_din_o,
    output logic         fifo_wr_en_o,
    output logic         fifo_inj_sbit_o,
    output logic         fifo_rd_en_o,
    input  logic [N-1:0] fifo_dout_i,
    input  logic         fifo_empty_i,
    input  logic         fifo_full_i,
    input  logic         fifo_sbiterr_i,
    input  logic         fifo_dbiterr_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRECHK = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [M-1:0] LAST_IDX = {M{1'b1}};

    logic [2:0]   state_q, state_d;
    logic [M-1:0] k_q, k_d;
    logic [M-1:0] j_q, j_d;
    logic [M-1:0] rd_idx_q, rd_idx_d;
    logic         rd_vld_q, rd_vld_d;
    logic [1:0]   settle_q, settle_d;
    logic [3:0]   stall_q, stall_d;
    logic [7:0]   err_cnt_q, err_cnt_d;
    logic         fifo_err_q, fifo_err_d;
    logic         pass_q, pass_d;
    logic [2:0]   cmp_inc, inc;
    logic [8:0]   cnt_sum;
    logic         wr_en, rd_en;

    function automatic logic [N-1:0] pattern(input logic [M-1:0] idx);
        if (idx == '0)
            return '1;
        else if (idx[0])
            return {(N/2){2'b10}};
        else
            return {(N/2){2'b01}};
    endfunction

    always_comb begin
        wr_en           = (state_q == S_WRITE) && !fifo_full_i;
        rd_en           = (state_q == S_READ) && !fifo_empty_i;
        fifo_wr_en_o    = wr_en;
        fifo_rd_en_o    = rd_en;
        fifo_din_o      = wr_en ? pattern(k_q) : '0;
        fifo_inj_sbit_o = wr_en && (k_q == '0);
        busy_o          = (state_q != S_IDLE);
        done_o          = (state_q == S_DONE);
        pass_o          = pass_q;
        fifo_err_o      = fifo_err_q;
        err_cnt_o       = err_cnt_q;
    end

    // Read data arrives one cycle after rd_en; only word 0 was written with an injected single-bit error.
    always_comb begin
        cmp_inc = 3'd0;
        if (rd_vld_q) begin
            if (fifo_dout_i != pattern(rd_idx_q))
                cmp_inc = cmp_inc + 3'd1;
            if ((rd_idx_q == '0) != fifo_sbiterr_i)
                cmp_inc = cmp_inc + 3'd1;
            if (fifo_dbiterr_i)
                cmp_inc = cmp_inc + 3'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        j_d      = j_q;
        settle_d = settle_q;
        stall_d  = stall_q;
        rd_vld_d = rd_en;
        rd_idx_d = j_q;
        inc      = cmp_inc;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_PRECHK;
                    k_d      = '0;
                    j_d      = '0;
                    settle_d = 2'd0;
                    stall_d  = 4'd0;
                end
            end
            S_PRECHK: begin
                if (fifo_empty_i) begin
                    state_d = S_WRITE;
                end else begin
                    inc     = inc + 3'd1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (!fifo_full_i) begin
                    stall_d = 4'd0;
                    if (k_q == LAST_IDX) begin
                        state_d  = S_SETTLE;
                        settle_d = 2'd0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else if (stall_q == 4'hF) begin
                    inc     = inc + 3'd1;
                    state_d = S_DONE;
                end else begin
                    stall_d = stall_q + 4'd1;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q + 2'd1;
                if (settle_q == 2'd3) begin
                    state_d = S_READ;
                    stall_d = 4'd0;
                end
            end
            S_READ: begin
                if (!fifo_empty_i) begin
                    stall_d = 4'd0;
                    if (j_q == LAST_IDX)
                        state_d = S_DRAIN;
                    else
                        j_d = j_q + 1'b1;
                end else if (stall_q == 4'hF) begin
                    inc     = inc + 3'd1;
                    state_d = S_DONE;
                end else begin
                    stall_d = stall_q + 4'd1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cnt_sum    = {1'b0, err_cnt_q} + {6'd0, inc};
        err_cnt_d  = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        fifo_err_d = fifo_err_q | (inc != 3'd0);
        pass_d     = pass_q;

        if ((state_q == S_IDLE) && start_i) begin
            err_cnt_d  = 8'd0;
            fifo_err_d = 1'b0;
            pass_d     = 1'b0;
        end

        // Resolve the verdict on entry to DONE so pass_o is valid alongside the done_o pulse.
        if ((state_d == S_DONE) && (state_q != S_DONE))
            pass_d = (err_cnt_d == 8'd0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            j_q        <= '0;
            rd_idx_q   <= '0;
            rd_vld_q   <= 1'b0;
            settle_q   <= 2'd0;
            stall_q    <= 4'd0;
            err_cnt_q  <= 8'd0;
            fifo_err_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            j_q        <= j_d;
            rd_idx_q   <= rd_idx_d;
            rd_vld_q   <= rd_vld_d;
            settle_q   <= settle_d;
            stall_q    <= stall_d;
            err_cnt_q  <= err_cnt_d;
            fifo_err_q <= fifo_err_d;
            pass_q     <= pass_d;
        end
    end

endmodule

// File: tb/tb_fifo_bist_ctrl.sv
// Bench for fifo_bist_ctrl: behavioural FIFO with fault knobs, write-data and run-result scoreboards.
module tb_fifo_bist_ctrl;

    localparam int N     = 32;
    localparam int M     = 3;
    localparam int DEPTH = 16;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic         start_i;
    logic         busy_o, done_o, pass_o, fifo_err_o;
    logic [7:0]   err_cnt_o;
    logic [N-1:0] fifo_din_o;
    logic         fifo_wr_en_o, fifo_inj_sbit_o, fifo_rd_en_o;
    logic [N-1:0] fifo_dout_i;
    logic         fifo_empty_i, fifo_full_i, fifo_sbiterr_i, fifo_dbiterr_i;

    typedef struct { logic [31:0] din; logic inj; } wrExp_t;
    typedef struct { logic [7:0] cnt; logic pass; } result_t;

    wrExp_t  wrQ[$];
    result_t resultQ[$];
    int      totalChecks = 0;
    int      badChecks   = 0;

    logic modeFlip, modeNoSbit, modeAllDbit, modeStuckFull, modeNotEmpty, flushReq;
    logic [N-1:0] mem [DEPTH];
    logic         injMem [DEPTH];
    int           cnt, wp, rp, wrCount, rdCount;

    always #5 clk_i = ~clk_i;

    fifo_bist_ctrl #(.N(N), .M(M)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .fifo_err_o     (fifo_err_o),
        .err_cnt_o      (err_cnt_o),
        .fifo_din_o     (fifo_din_o),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_inj_sbit_o(fifo_inj_sbit_o),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .fifo_dout_i    (fifo_dout_i),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_full_i    (fifo_full_i),
        .fifo_sbiterr_i (fifo_sbiterr_i),
        .fifo_dbiterr_i (fifo_dbiterr_i)
    );

    assign fifo_empty_i = (cnt == 0) && !modeNotEmpty;
    assign fifo_full_i  = (cnt == DEPTH) || (modeStuckFull && (wrCount >= 2));

    // Ideal FIFO with one-cycle read latency, plus fault knobs for corruption and flag errors.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i || flushReq) begin
            cnt <= 0; wp <= 0; rp <= 0; wrCount <= 0; rdCount <= 0;
            fifo_dout_i <= '0; fifo_sbiterr_i <= 1'b0; fifo_dbiterr_i <= 1'b0;
        end else begin
            if (fifo_wr_en_o && !fifo_full_i) begin
                mem[wp]    <= fifo_din_o;
                injMem[wp] <= fifo_inj_sbit_o;
                wp         <= (wp + 1) % DEPTH;
                wrCount    <= wrCount + 1;
            end
            if (fifo_rd_en_o && cnt > 0) begin
                fifo_dout_i    <= mem[rp] ^ ((modeFlip && rdCount == 3) ? 32'h10 : 32'h0);
                fifo_sbiterr_i <= injMem[rp] && !modeNoSbit;
                fifo_dbiterr_i <= modeAllDbit;
                rp             <= (rp + 1) % DEPTH;
                rdCount        <= rdCount + 1;
            end
            cnt <= cnt + ((fifo_wr_en_o && !fifo_full_i) ? 1 : 0) - ((fifo_rd_en_o && cnt > 0) ? 1 : 0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rstn_i === 1'b1) begin
            if (fifo_wr_en_o) begin
                checkOutput("wrRdExclusive", {31'd0, fifo_rd_en_o}, 32'd0);
                if (wrQ.size() == 0) begin
                    checkOutput("unexpectedWrite", {31'd0, fifo_wr_en_o}, 32'd0);
                end else begin
                    wrExp_t e;
                    e = wrQ.pop_front();
                    checkOutput("writeData", fifo_din_o, e.din);
                    checkOutput("injSbit", {31'd0, fifo_inj_sbit_o}, {31'd0, e.inj});
                end
            end
            if (done_o) begin
                if (resultQ.size() == 0) begin
                    checkOutput("unexpectedDone", {31'd0, done_o}, 32'd0);
                end else begin
                    result_t r;
                    r = resultQ.pop_front();
                    checkOutput("errCnt", {24'd0, err_cnt_o}, {24'd0, r.cnt});
                    checkOutput("pass", {31'd0, pass_o}, {31'd0, r.pass});
                    checkOutput("fifoErr", {31'd0, fifo_err_o}, {31'd0, (r.cnt != 8'd0)});
                    checkOutput("busyAtDone", {31'd0, busy_o}, 32'd1);
                end
            end
        end
    end

    function automatic logic [31:0] expWord(input int k);
        if (k == 0)          return 32'hFFFF_FFFF;
        else if (k % 2 == 1) return 32'hAAAA_AAAA;
        else                 return 32'h5555_5555;
    endfunction

    task automatic setupRun(input logic flip, input logic noSbit, input logic allDbit,
                            input logic stuck, input logic notEmpty, input int nWrites);
        @(negedge clk_i);
        flushReq = 1'b1;
        modeFlip = flip; modeNoSbit = noSbit; modeAllDbit = allDbit;
        modeStuckFull = stuck; modeNotEmpty = notEmpty;
        @(negedge clk_i);
        flushReq = 1'b0;
        for (int k = 0; k < nWrites; k++) begin
            wrExp_t e;
            e.din = expWord(k);
            e.inj = (k == 0);
            wrQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic flip, input logic noSbit, input logic allDbit,
                                 input logic stuck, input logic notEmpty, input int nWrites,
                                 input logic [7:0] expCnt, input int expLat);
        result_t r;
        int      cyc;
        logic    seen;
        setupRun(flip, noSbit, allDbit, stuck, notEmpty, nWrites);
        r.cnt  = expCnt;
        r.pass = (expCnt == 8'd0);
        resultQ.push_back(r);
        start_i = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            if (cyc >= 2) start_i = 1'b0;
            if (done_o) seen = 1'b1;
        end
        start_i = 1'b0;
        checkOutput("doneSeen", {31'd0, seen}, 32'd1);
        if (expLat > 0) checkOutput("doneLatency", cyc, expLat);
        if (notEmpty)   checkOutput("rejectWithin3", {31'd0, (cyc <= 3)}, 32'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("passHeld", {31'd0, pass_o}, {31'd0, (expCnt == 8'd0)});
        checkOutput("errCntHeld", {24'd0, err_cnt_o}, {24'd0, expCnt});
        checkOutput("busyIdle", {31'd0, busy_o}, 32'd0);
        checkOutput("writesLeft", wrQ.size(), 0);
        wrQ.delete();
        resultQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
        checkOutput({tag, "_done"},  {31'd0, done_o}, 32'd0);
        checkOutput({tag, "_pass"},  {31'd0, pass_o}, 32'd0);
        checkOutput({tag, "_ferr"},  {31'd0, fifo_err_o}, 32'd0);
        checkOutput({tag, "_cnt"},   {24'd0, err_cnt_o}, 32'd0);
        checkOutput({tag, "_din"},   fifo_din_o, 32'd0);
        checkOutput({tag, "_wr"},    {31'd0, fifo_wr_en_o}, 32'd0);
        checkOutput({tag, "_rd"},    {31'd0, fifo_rd_en_o}, 32'd0);
        checkOutput({tag, "_inj"},   {31'd0, fifo_inj_sbit_o}, 32'd0);
    endtask

    initial begin
        int   cyc;
        logic inRead;
        rstn_i = 1'b1; start_i = 1'b0; flushReq = 1'b0;
        modeFlip = 1'b0; modeNoSbit = 1'b0; modeAllDbit = 1'b0;
        modeStuckFull = 1'b0; modeNotEmpty = 1'b0;
        #2 rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkAllZero("reset");
        rstn_i = 1'b1;
        @(negedge clk_i);
        checkOutput("idleAfterRelease", {31'd0, busy_o}, 32'd0);

        $display("[TB] ideal FIFO run");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 8'd0, 23);
        $display("[TB] corrupted word 3");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 8'd1, 23);
        $display("[TB] missing sbiterr");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8, 8'd1, 23);
        $display("[TB] dbiterr on every word");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8, 8'd8, 23);
        $display("[TB] full stuck from write 2");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 8'd1, 20);
        $display("[TB] non-empty FIFO at start");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'd1, 2);

        $display("[TB] reset during READ");
        setupRun(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        start_i = 1'b1;
        cyc = 0;
        inRead = 1'b0;
        while (!inRead && cyc < 100) begin
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            start_i = 1'b0;
            if (fifo_rd_en_o) inRead = 1'b1;
        end
        checkOutput("reachedRead", {31'd0, inRead}, 32'd1);
        rstn_i = 1'b0;
        #1;
        checkAllZero("abort");
        checkOutput("abortWritesLeft", wrQ.size(), 0);
        wrQ.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (5) @(negedge clk_i);
        checkOutput("noRestart", {31'd0, busy_o}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 8'd0, 23);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
